// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute/update sequencer driving the PC control pins
// and the instruction-fetch handshake, with start/halt, fetch timeout and retire count.
module fetch_sequencer #(
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter logic [15:0] RETIRED_INIT  = 16'h0000
) (
    input  logic        clk,
    input  logic        r,
    input  logic        run,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        exec_done,
    input  logic        branch_take,
    input  logic [15:0] branch_target,
    input  logic        halt_req,
    output logic        pc_we,
    output logic        pc_oe,
    output logic        pc_e,
    output logic [15:0] pc_load,
    output logic        mem_req,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        bus_sel,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retired,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        run_q, run_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] pc_load_q, pc_load_d;
    logic [15:0] retired_q, retired_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        br_q, br_d;
    logic        halt_q, halt_d;
    logic        run_rise;

    assign run_rise = run & ~run_q;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            ir_q      <= 16'h0000;
            pc_load_q <= 16'h0000;
            retired_q <= RETIRED_INIT;
            tmo_q     <= 8'h00;
            br_q      <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            ir_q      <= ir_d;
            pc_load_q <= pc_load_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
            br_q      <= br_d;
            halt_q    <= halt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_d     = run;
        ir_d      = ir_q;
        pc_load_d = pc_load_q;
        retired_d = retired_q;
        tmo_d     = 8'h00;
        br_d      = br_q;
        halt_d    = halt_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (run_rise) state_d = S_FETCH;
            end
            S_FETCH: begin
                // An ack on the final allowed cycle still beats the timeout.
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (exec_done) begin
                    br_d      = branch_take;
                    halt_d    = halt_req;
                    pc_load_d = branch_target;
                    state_d   = S_UPDATE;
                end
            end
            S_UPDATE: begin
                retired_d = retired_q + 16'd1;
                state_d   = halt_q ? S_HALT : S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_we    = 1'b0;
        pc_oe    = 1'b0;
        pc_e     = 1'b0;
        mem_req  = 1'b0;
        ir_valid = 1'b0;
        bus_sel  = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: halted = 1'b1;
            S_FETCH: begin
                mem_req = 1'b1;
                pc_oe   = 1'b1;
            end
            S_DECODE: ir_valid = 1'b1;
            S_EXEC:   bus_sel  = 1'b1;
            // Load and increment are mutually exclusive by construction.
            S_UPDATE: begin
                pc_we = br_q;
                pc_e  = ~br_q;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign pc_load   = pc_load_q;
    assign ir        = ir_q;
    assign retired   = retired_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized instruction
// stream checked against an instruction-level reference model.
module tb_fetch_sequencer;

  logic        clk;
  logic        r;
  logic        run;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        exec_done;
  logic        branch_take;
  logic [15:0] branch_target;
  logic        halt_req;

  logic        pc_we, pc_oe, pc_e, mem_req, ir_valid, bus_sel, halted, fault;
  logic [15:0] pc_load, ir, retired;
  logic [2:0]  state_dbg;

  logic        w_pc_we, w_pc_oe, w_pc_e, w_mem_req, w_ir_valid, w_bus_sel, w_halted, w_fault;
  logic [15:0] w_pc_load, w_ir, w_retired;
  logic [2:0]  w_state_dbg;

  int checks = 0;
  int errors = 0;
  int model_retired = 0;
  int pce_seen = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  fetch_sequencer #(.FETCH_TIMEOUT(4)) dut (
    .clk(clk), .r(r), .run(run), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .exec_done(exec_done), .branch_take(branch_take), .branch_target(branch_target),
    .halt_req(halt_req), .pc_we(pc_we), .pc_oe(pc_oe), .pc_e(pc_e), .pc_load(pc_load),
    .mem_req(mem_req), .ir(ir), .ir_valid(ir_valid), .bus_sel(bus_sel), .halted(halted),
    .fault(fault), .retired(retired), .state_dbg(state_dbg)
  );

  // Second instance starts its retire count at 0xFFFF to exercise the wrap.
  fetch_sequencer #(.FETCH_TIMEOUT(16), .RETIRED_INIT(16'hFFFF)) dut_w (
    .clk(clk), .r(r), .run(run), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .exec_done(exec_done), .branch_take(branch_take), .branch_target(branch_target),
    .halt_req(halt_req), .pc_we(w_pc_we), .pc_oe(w_pc_oe), .pc_e(w_pc_e), .pc_load(w_pc_load),
    .mem_req(w_mem_req), .ir(w_ir), .ir_valid(w_ir_valid), .bus_sel(w_bus_sel), .halted(w_halted),
    .fault(w_fault), .retired(w_retired), .state_dbg(w_state_dbg)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (pc_e === 1'b1) pce_seen++;

  task automatic do_reset();
    r = 1'b1;
    run = 1'b0;
    mem_ack = 1'b0;
    exec_done = 1'b0;
    halt_req = 1'b0;
    branch_take = 1'b0;
    @(negedge clk);
    r = 1'b0;
    model_retired = 0;
    exp_q.delete();
  endtask

  task automatic start_run();
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL start_fetch mem_req=%b halted=%b expected mem_req=1 halted=0", mem_req, halted);
    end
  endtask

  // Driver for one instruction, entered and left at a negedge with the DUT in FETCH.
  task automatic run_instr(input int ack_dly, input int exec_dly, input logic [15:0] word,
                           input logic take, input logic [15:0] tgt, input logic hlt);
    logic [15:0] exp_ir;
    logic [15:0] exp_w;
    checks++;
    if (mem_req !== 1'b1 || pc_oe !== 1'b1 || bus_sel !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ctl mem_req=%b pc_oe=%b bus_sel=%b expected 1 1 0", mem_req, pc_oe, bus_sel);
    end
    for (int k = 0; k < ack_dly; k++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || fault !== 1'b0) begin
        errors++;
        $display("FAIL fetch_wait mem_req=%b fault=%b expected 1 0", mem_req, fault);
      end
    end
    mem_ack = 1'b1;
    mem_rdata = word;
    exp_q.push_back(word);
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 16'($urandom);
    exp_ir = exp_q.pop_front();
    checks++;
    if (ir_valid !== 1'b1 || ir !== exp_ir || mem_req !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL decode ir_valid=%b ir=%h mem_req=%b fault=%b expected 1 %h 0 0",
               ir_valid, ir, mem_req, fault, exp_ir);
    end
    @(negedge clk);
    checks++;
    if (ir_valid !== 1'b0 || bus_sel !== 1'b1 || pc_oe !== 1'b0) begin
      errors++;
      $display("FAIL exec_entry ir_valid=%b bus_sel=%b pc_oe=%b expected 0 1 0", ir_valid, bus_sel, pc_oe);
    end
    for (int k = 0; k < exec_dly; k++) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      checks++;
      if (bus_sel !== 1'b1 || pc_we !== 1'b0 || pc_e !== 1'b0 || ir !== exp_ir) begin
        errors++;
        $display("FAIL exec_wait bus_sel=%b pc_we=%b pc_e=%b ir=%h expected 1 0 0 %h",
                 bus_sel, pc_we, pc_e, ir, exp_ir);
      end
    end
    mem_ack = 1'b0;
    exec_done = 1'b1;
    branch_take = take;
    branch_target = tgt;
    halt_req = hlt;
    @(negedge clk);
    exec_done = 1'b0;
    branch_take = 1'($urandom);
    branch_target = 16'($urandom);
    halt_req = 1'($urandom);
    checks++;
    if (pc_we !== take || pc_e !== ~take || (take && pc_load !== tgt) || bus_sel !== 1'b0) begin
      errors++;
      $display("FAIL update pc_we=%b pc_e=%b pc_load=%h bus_sel=%b expected %b %b %h 0",
               pc_we, pc_e, pc_load, bus_sel, take, ~take, tgt);
    end
    model_retired++;
    exp_w = 16'hFFFF + 16'(model_retired);
    @(negedge clk);
    branch_take = 1'b0;
    halt_req = 1'b0;
    checks++;
    if (retired !== 16'(model_retired) || w_retired !== exp_w) begin
      errors++;
      $display("FAIL retired got=%h/%h expected %h/%h", retired, w_retired, 16'(model_retired), exp_w);
    end
    checks++;
    if (halted !== hlt || mem_req !== ~hlt || pc_we !== 1'b0 || pc_e !== 1'b0) begin
      errors++;
      $display("FAIL after_update halted=%b mem_req=%b pc_we=%b pc_e=%b expected %b %b 0 0",
               halted, mem_req, pc_we, pc_e, hlt, ~hlt);
    end
  endtask

  task automatic test_reset();
    r = 1'b1;
    run = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    exec_done = 1'b0;
    branch_take = 1'b0;
    branch_target = 16'h0000;
    halt_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || pc_we !== 1'b0 || pc_oe !== 1'b0 || pc_e !== 1'b0 || mem_req !== 1'b0 ||
        ir_valid !== 1'b0 || bus_sel !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl halted=%b we=%b oe=%b e=%b req=%b irv=%b bus=%b fault=%b expected 1 0 0 0 0 0 0 0",
               halted, pc_we, pc_oe, pc_e, mem_req, ir_valid, bus_sel, fault);
    end
    checks++;
    if (ir !== 16'h0 || pc_load !== 16'h0 || retired !== 16'h0 || w_retired !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_regs ir=%h pc_load=%h retired=%h w_retired=%h expected 0 0 0 ffff",
               ir, pc_load, retired, w_retired);
    end
    r = 1'b0;
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold halted=%b mem_req=%b expected 1 0", halted, mem_req);
    end
  endtask

  task automatic test_straight_line();
    int c0, p0;
    start_run();
    c0 = cyc;
    p0 = pce_seen;
    run_instr(0, 0, 16'h1111, 1'b0, 16'h0, 1'b0);
    run_instr(0, 0, 16'h2222, 1'b0, 16'h0, 1'b0);
    run_instr(0, 0, 16'h3333, 1'b0, 16'h0, 1'b0);
    checks++;
    if (cyc - c0 != 12 || pce_seen - p0 != 3 || retired !== 16'd3) begin
      errors++;
      $display("FAIL straight_line cycles=%0d pc_e_pulses=%0d retired=%0d expected 12 3 3",
               cyc - c0, pce_seen - p0, retired);
    end
  endtask

  task automatic test_branch();
    run_instr(0, 1, 16'hA5A5, 1'b1, 16'hFFFF, 1'b0);
    run_instr(1, 0, 16'h5A5A, 1'b0, 16'h1234, 1'b0);
  endtask

  task automatic test_halt_run_held();
    run_instr(0, 0, 16'hBEEF, 1'b1, 16'h0040, 1'b1);
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || pc_load !== 16'h0040) begin
        errors++;
        $display("FAIL halt_hold halted=%b mem_req=%b pc_load=%h expected 1 0 0040", halted, mem_req, pc_load);
      end
    end
    start_run();
  endtask

  task automatic test_random();
    logic hlt;
    for (int i = 0; i < 12; i++) begin
      hlt = ($urandom_range(0, 3) == 0);
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom),
                1'($urandom), 16'($urandom), hlt);
      if (hlt) start_run();
    end
  endtask

  task automatic test_async_reset_exec();
    do_reset();
    start_run();
    run_instr(0, 0, 16'h0F0F, 1'b0, 16'h0, 1'b0);
    mem_ack = 1'b1;
    mem_rdata = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    #2 r = 1'b1;
    #1;
    checks++;
    if (bus_sel !== 1'b0 || halted !== 1'b1 || retired !== 16'h0 || w_retired !== 16'hFFFF || ir !== 16'h0) begin
      errors++;
      $display("FAIL async_reset_exec bus_sel=%b halted=%b retired=%h w_retired=%h ir=%h expected 0 1 0 ffff 0",
               bus_sel, halted, retired, w_retired, ir);
    end
    @(negedge clk);
    r = 1'b0;
    model_retired = 0;
    exp_q.delete();
  endtask

  task automatic test_timeout();
    do_reset();
    start_run();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || fault !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait cycle=%0d mem_req=%b fault=%b expected 1 0", k, mem_req, fault);
      end
    end
    @(negedge clk);
    checks++;
    if (fault !== 1'b1 || mem_req !== 1'b0 || pc_oe !== 1'b0 || halted !== 1'b0 || bus_sel !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fault fault=%b mem_req=%b pc_oe=%b halted=%b bus_sel=%b expected 1 0 0 0 0",
               fault, mem_req, pc_oe, halted, bus_sel);
    end
    run = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    run = 1'b1;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (fault !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky fault=%b mem_req=%b expected 1 0", fault, mem_req);
    end
    #2 r = 1'b1;
    #1;
    checks++;
    if (fault !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL fault_clear fault=%b halted=%b expected 0 1", fault, halted);
    end
    @(negedge clk);
    r = 1'b0;
    model_retired = 0;
    exp_q.delete();
  endtask

  task automatic test_ack_boundary();
    start_run();
    run_instr(3, 0, 16'hC3C3, 1'b0, 16'h0, 1'b0);
    #2 r = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || pc_oe !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_fetch mem_req=%b pc_oe=%b halted=%b expected 0 0 1", mem_req, pc_oe, halted);
    end
    @(negedge clk);
    r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_branch();
    test_halt_run_held();
    test_random();
    test_async_reset_exec();
    test_timeout();
    test_ack_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle fetch/execute sequencer that owns the 16-bit program counter's control pins (we, oe, e) and the instruction-fetch memory handshake. Each instruction goes through fetch, decode, execute-wait and PC update. Taken branches load the PC; all other instructions increment it. The block also provides start/halt control, a fetch-timeout fault and a retired-instruction counter.

Parameters:
FETCH_TIMEOUT, 16, max FETCH cycles without mem_ack before FAULT; legal range 2..255.

Ports:
clk  in  1  system clock, rising edge
r  in  1  reset, asynchronous, active-high
run  in  1  start/resume request; acts on its rising edge
mem_ack  in  1  fetch memory has valid data on mem_rdata this cycle
mem_rdata  in  16  fetched instruction word
exec_done  in  1  execute unit finished current instruction (single-cycle pulse)
branch_take  in  1  sampled with exec_done: load PC from branch_target
branch_target  in  16  sampled with exec_done
halt_req  in  1  sampled with exec_done: stop after this instruction
pc_we  out  1  PC parallel load strobe
pc_oe  out  1  PC drives address bus
pc_e  out  1  PC increment enable
pc_load  out  16  value presented to PC load input
mem_req  out  1  fetch request
ir  out  16  instruction register
ir_valid  out  1  ir holds a new instruction (one-cycle pulse)
bus_sel  out  1  0 = PC owns address bus, 1 = execute datapath owns it
halted  out  1  high in IDLE and HALT
fault  out  1  fetch timeout occurred; sticky until r
retired  out  16  instructions completed; wraps 0xFFFF -> 0x0000

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT, FAULT. State is registered; outputs are decoded from state unless stated otherwise.
- Reset (async, r=1): state=IDLE. ir, pc_load, retired, timeout counter and run_q all 0. All control outputs 0 except halted=1. Reset mid-fetch drops mem_req and pc_oe immediately, without waiting for clk.
- run edge detect: run_q is a registered copy of run. run_rise = run & ~run_q. Holding run high across a HALT does not restart the sequencer.
- IDLE / HALT: halted=1. On run_rise, go to FETCH next cycle.
- FETCH: mem_req=1, pc_oe=1, bus_sel=0.
  - On a clk edge with mem_ack=1: ir<=mem_rdata, clear timeout counter, go to DECODE.
  - Otherwise increment the timeout counter. If the counter equals FETCH_TIMEOUT-1 and mem_ack=0, go to FAULT.
  - If mem_ack arrives on the same edge the timeout is reached, mem_ack wins.
- DECODE: ir_valid=1 for exactly one cycle, then go to EXEC.
- EXEC: bus_sel=1 and pc_oe=0 for the whole state. Wait indefinitely for exec_done.
  - On exec_done, capture branch_take, branch_target and halt_req into internal registers, then go to UPDATE.
- UPDATE: lasts exactly one cycle; retired increments by 1.
  - Branch taken: pc_we=1, pc_load=captured target, pc_e=0. pc_e must never be high together with pc_we.
  - Branch not taken: pc_e=1, pc_we=0. The PC wraps 0xFFFF -> 0 on its own.
  - Next state: HALT if halt was captured, else FETCH. Branch and halt together: the PC is loaded first, then HALT.
- FAULT: fault=1 and all other control outputs 0. Exit only via r.
- Minimum cycles per instruction: FETCH(1) + DECODE(1) + EXEC(1) + UPDATE(1) = 4 when mem_ack and exec_done both arrive on first sight.
- exec_done, mem_ack and run are ignored in every state other than the one that consumes them.

Test Plan:
- Straight-line run: reset, run_rise, mem_ack and exec_done each asserted on their first cycle, no branch, 3 instructions -> 12 cycles; pc_e pulses 3 times; retired=3; ir follows mem_rdata 0x1111, 0x2222, 0x3333; ir_valid pulses once per instruction.
- Taken branch: exec_done with branch_take=1, branch_target=0xFFFF -> UPDATE has pc_we=1, pc_load=0xFFFF, pc_e=0. Next instruction not taken -> pc_e=1 (PC wraps to 0).
- Halt with run held high: halt_req=1 together with branch_take=1, target=0x0040 -> pc_we pulses with 0x0040, state HALT, halted=1. run held at 1 causes no restart; run dropped to 0 then raised -> FETCH on the next cycle.
- Timeout: FETCH_TIMEOUT=4, mem_ack never asserted -> FAULT entered after 4 FETCH cycles; fault=1, mem_req=0. run_rise is ignored; only r clears fault.
- Ack at the boundary: mem_ack asserted on the 4th FETCH cycle with FETCH_TIMEOUT=4 -> DECODE entered, fault stays 0.
- Async reset mid-EXEC and retired wrap:
  - r asserted between clock edges during EXEC -> bus_sel=0, halted=1, retired=0 with no clk edge needed.
  - Preloaded retired=0xFFFF plus one completed instruction -> retired=0x0000.
